// File: rtl/hdc_csr_sequencer.sv
// Drives an HDC accelerator through its CSR port: configures it, streams samples in,
// polls for completion and returns the class result, with a bounded status-poll timeout.
module hdc_csr_sequencer #(
  parameter int CSR_WIDTH      = 32,
  parameter int CSR_ADDR_WIDTH = 32,
  parameter int POLL_LIMIT     = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [2:0]                cfg_binding_i,
  input  logic [23:0]               cfg_bundling_i,
  input  logic [CSR_WIDTH-1:0]      cfg_am_base_i,
  input  logic [CSR_WIDTH-1:0]      cfg_am_max_i,
  input  logic                      smp_valid_i,
  output logic                      smp_ready_o,
  input  logic [5:0]                smp_value_i,
  input  logic [5:0]                smp_shift_i,
  input  logic                      smp_last_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_WIDTH-1:0]      csr_wr_data_o,
  output logic                      csr_wr_en_o,
  output logic                      csr_req_valid_o,
  input  logic                      csr_req_ready_i,
  input  logic [CSR_WIDTH-1:0]      csr_rd_data_i,
  input  logic                      csr_rsp_valid_i,
  output logic                      busy_o,
  output logic                      result_valid_o,
  output logic [4:0]                result_o,
  output logic                      timeout_o
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    IDLE, W_RST, W_BIND, W_BUND, W_BASE, W_MAX, W_START, GET_SMP,
    POLL_RDY, W_IN, W_CLR, W_DONE, POLL_OUT, FINISH, ERR
  } state_t;

  state_t                state_reg, state_next;
  logic [2:0]            binding_reg;
  logic [23:0]           bundling_reg;
  logic [CSR_WIDTH-1:0]  am_base_reg, am_max_reg;
  logic [5:0]            value_reg, shift_reg;
  logic                  last_reg;
  logic [CNT_W-1:0]      poll_cnt_reg, poll_cnt_next;
  logic [4:0]            result_reg;
  logic                  timeout_reg;
  logic                  rdy_hit, out_hit, poll_last;
  logic                  rd_unused;

  // A status read only counts as a match when the response carried data.
  assign rdy_hit   = csr_req_ready_i && csr_rsp_valid_i && csr_rd_data_i[1];
  assign out_hit   = csr_req_ready_i && csr_rsp_valid_i && csr_rd_data_i[2];
  assign poll_last = (poll_cnt_reg == CNT_W'(POLL_LIMIT - 1));
  assign rd_unused = ^{csr_rd_data_i[CSR_WIDTH-1:8], csr_rd_data_i[0]};

  assign busy_o         = (state_reg != IDLE);
  assign result_valid_o = (state_reg == FINISH);
  assign result_o       = result_reg;
  assign timeout_o      = timeout_reg;

  always_comb begin
    state_next      = state_reg;
    poll_cnt_next   = poll_cnt_reg;
    smp_ready_o     = 1'b0;
    csr_req_valid_o = 1'b0;
    csr_wr_en_o     = 1'b0;
    csr_addr_o      = '0;
    csr_wr_data_o   = '0;
    case (state_reg)
      IDLE: if (start_i) state_next = W_RST;
      W_RST, ERR: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(7);
        csr_wr_data_o   = CSR_WIDTH'(1);
        if (csr_req_ready_i) state_next = (state_reg == ERR) ? IDLE : W_BIND;
      end
      W_BIND: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(3);
        csr_wr_data_o   = CSR_WIDTH'(binding_reg);
        if (csr_req_ready_i) state_next = W_BUND;
      end
      W_BUND: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(4);
        csr_wr_data_o   = CSR_WIDTH'(bundling_reg);
        if (csr_req_ready_i) state_next = W_BASE;
      end
      W_BASE: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(5);
        csr_wr_data_o   = am_base_reg;
        if (csr_req_ready_i) state_next = W_MAX;
      end
      W_MAX: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(6);
        csr_wr_data_o   = am_max_reg;
        if (csr_req_ready_i) state_next = W_START;
      end
      W_START: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = '0;
        csr_wr_data_o   = CSR_WIDTH'(1);
        if (csr_req_ready_i) state_next = GET_SMP;
      end
      GET_SMP: begin
        smp_ready_o = 1'b1;
        if (smp_valid_i) begin
          state_next    = POLL_RDY;
          poll_cnt_next = '0;
        end
      end
      POLL_RDY, POLL_OUT: begin
        csr_req_valid_o = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(2);
        // A match on the last allowed poll wins over the timeout.
        if (state_reg == POLL_RDY && rdy_hit) state_next = W_IN;
        else if (state_reg == POLL_OUT && out_hit) state_next = FINISH;
        else if (csr_req_ready_i) begin
          if (poll_last) state_next = ERR;
          else poll_cnt_next = poll_cnt_reg + 1'b1;
        end
      end
      W_IN, W_CLR: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(1);
        csr_wr_data_o   = CSR_WIDTH'({shift_reg, value_reg, (state_reg == W_IN)});
        if (csr_req_ready_i) begin
          if (state_reg == W_IN) state_next = W_CLR;
          else state_next = last_reg ? W_DONE : GET_SMP;
        end
      end
      W_DONE: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CSR_ADDR_WIDTH'(1);
        csr_wr_data_o   = CSR_WIDTH'(14'h2000);
        if (csr_req_ready_i) begin
          state_next    = POLL_OUT;
          poll_cnt_next = '0;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      binding_reg  <= '0;
      bundling_reg <= '0;
      am_base_reg  <= '0;
      am_max_reg   <= '0;
      value_reg    <= '0;
      shift_reg    <= '0;
      last_reg     <= 1'b0;
      poll_cnt_reg <= '0;
      result_reg   <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      poll_cnt_reg <= poll_cnt_next;
      if (state_reg == IDLE && start_i) begin
        binding_reg  <= cfg_binding_i;
        bundling_reg <= cfg_bundling_i;
        am_base_reg  <= cfg_am_base_i;
        am_max_reg   <= cfg_am_max_i;
        timeout_reg  <= 1'b0;
      end
      if (state_reg == GET_SMP && smp_valid_i) begin
        value_reg <= smp_value_i;
        shift_reg <= smp_shift_i;
        last_reg  <= smp_last_i;
      end
      if (state_reg == POLL_OUT && out_hit) result_reg <= csr_rd_data_i[7:3];
      if (state_next == ERR && state_reg != ERR) timeout_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdc_csr_sequencer.sv
// Directed bench: expected CSR transfer tables per job, replayed against a CSR slave model
// that logs every completed transfer and optionally holds off ready.
module tb_hdc_csr_sequencer;
  localparam int CW = 32;
  localparam int AW = 32;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [2:0]    cfg_binding_i;
  logic [23:0]   cfg_bundling_i;
  logic [CW-1:0] cfg_am_base_i, cfg_am_max_i;
  logic          smp_valid_i, smp_ready_o, smp_last_i;
  logic [5:0]    smp_value_i, smp_shift_i;
  logic [AW-1:0] csr_addr_o;
  logic [CW-1:0] csr_wr_data_o, csr_rd_data_i;
  logic          csr_wr_en_o, csr_req_valid_o, csr_req_ready_i, csr_rsp_valid_i;
  logic          busy_o, result_valid_o, timeout_o;
  logic [4:0]    result_o;

  always #5 clk = ~clk;

  hdc_csr_sequencer #(.CSR_WIDTH(CW), .CSR_ADDR_WIDTH(AW), .POLL_LIMIT(PL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .cfg_binding_i(cfg_binding_i), .cfg_bundling_i(cfg_bundling_i),
    .cfg_am_base_i(cfg_am_base_i), .cfg_am_max_i(cfg_am_max_i),
    .smp_valid_i(smp_valid_i), .smp_ready_o(smp_ready_o), .smp_value_i(smp_value_i),
    .smp_shift_i(smp_shift_i), .smp_last_i(smp_last_i),
    .csr_addr_o(csr_addr_o), .csr_wr_data_o(csr_wr_data_o), .csr_wr_en_o(csr_wr_en_o),
    .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
    .csr_rd_data_i(csr_rd_data_i), .csr_rsp_valid_i(csr_rsp_valid_i),
    .busy_o(busy_o), .result_valid_o(result_valid_o), .result_o(result_o), .timeout_o(timeout_o)
  );

  // One record per CSR transfer: write data, or the status value the slave returns on a read.
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       log_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_delay = 0;
  int          wait_cnt = 0;
  int          rv_count = 0;
  int          rv0;
  logic [31:0] hold_addr, hold_data;
  logic        hold_wr;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CSR slave: holds ready low for ready_delay cycles per request, checks the request is stable.
  initial begin
    csr_req_ready_i = 1'b0;
    csr_rsp_valid_i = 1'b0;
    csr_rd_data_i   = '0;
    forever begin
      @(negedge clk);
      csr_req_ready_i = 1'b0;
      csr_rsp_valid_i = 1'b0;
      csr_rd_data_i   = '0;
      if (rst_ni && csr_req_valid_o) begin
        if (wait_cnt == 0) begin
          hold_wr   = csr_wr_en_o;
          hold_addr = csr_addr_o;
          hold_data = csr_wr_data_o;
        end else begin
          check("req_stable", 96'({csr_wr_en_o, csr_addr_o, csr_wr_data_o}),
                96'({hold_wr, hold_addr, hold_data}));
        end
        if (wait_cnt >= ready_delay) begin
          csr_req_ready_i = 1'b1;
          if (!csr_wr_en_o) begin
            csr_rsp_valid_i = 1'b1;
            if (rd_q.size() > 0) csr_rd_data_i = rd_q.pop_front();
            log_q.push_back({1'b0, csr_addr_o, csr_rd_data_i});
          end else begin
            log_q.push_back({1'b1, csr_addr_o, csr_wr_data_o});
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (result_valid_o) rv_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_r(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b0, a, d});
    rd_q.push_back(d);
  endtask

  task automatic exp_cfg(input logic [2:0] b, input logic [23:0] bu, input logic [31:0] base,
                         input logic [31:0] mx);
    exp_w(32'd7, 32'd1);
    exp_w(32'd3, {29'b0, b});
    exp_w(32'd4, {8'b0, bu});
    exp_w(32'd5, base);
    exp_w(32'd6, mx);
    exp_w(32'd0, 32'd1);
  endtask

  task automatic exp_sample(input logic [5:0] v, input logic [5:0] s, input int busy_polls);
    for (int k = 0; k < busy_polls; k++) exp_r(32'd2, 32'h0);
    exp_r(32'd2, 32'h2);
    exp_w(32'd1, {18'b0, 1'b0, s, v, 1'b1});
    exp_w(32'd1, {18'b0, 1'b0, s, v, 1'b0});
  endtask

  task automatic exp_done(input logic [4:0] res, input int busy_polls);
    exp_w(32'd1, 32'h2000);
    for (int k = 0; k < busy_polls; k++) exp_r(32'd2, 32'h2);
    exp_r(32'd2, 32'h6 | ({27'b0, res} << 3));
  endtask

  task automatic start_job(input logic [2:0] b, input logic [23:0] bu, input logic [31:0] base,
                           input logic [31:0] mx);
    @(negedge clk);
    cfg_binding_i = b; cfg_bundling_i = bu; cfg_am_base_i = base; cfg_am_max_i = mx;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cfg_binding_i = ~b; cfg_bundling_i = ~bu; cfg_am_base_i = ~base; cfg_am_max_i = ~mx;
  endtask

  task automatic send_sample(input logic [5:0] v, input logic [5:0] s, input logic last,
                             input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    smp_value_i = v; smp_shift_i = s; smp_last_i = last; smp_valid_i = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (smp_ready_o) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    smp_valid_i = 1'b0; smp_value_i = '0; smp_shift_i = '0; smp_last_i = 1'b0;
    check("smp_handshake", 96'(ok), 96'(1));
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    check({name, "_idle"}, 96'(busy_o), 96'(0));
  endtask

  task automatic compare_log(input string name);
    check({name, "_xfer_count"}, 96'(log_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) check($sformatf("%s_xfer%0d", name, i), 96'(log_q[i]), 96'(exp_q[i]));
    end
    exp_q.delete();
    log_q.delete();
    rd_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 96'({smp_ready_o, csr_wr_en_o, csr_req_valid_o, busy_o, result_valid_o,
                               result_o, timeout_o}), 96'(0));
    check({name, "_bus"}, 96'({csr_addr_o, csr_wr_data_o}), 96'(0));
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0;
    cfg_binding_i = '0; cfg_bundling_i = '0; cfg_am_base_i = '0; cfg_am_max_i = '0;
    smp_valid_i = 1'b0; smp_value_i = '0; smp_shift_i = '0; smp_last_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Config chain followed by a single sample whose result needs a second status read.
    exp_cfg(3'b101, 24'h8A1234, 32'h100, 32'h1FF);
    exp_sample(6'd21, 6'd3, 0);
    exp_done(5'd9, 1);
    rv0 = rv_count;
    start_job(3'b101, 24'h8A1234, 32'h100, 32'h1FF);
    send_sample(6'd21, 6'd3, 1'b1, 0);
    wait_idle("single");
    compare_log("single");
    check("single_result", 96'(result_o), 96'(9));
    check("single_pulse", 96'(rv_count - rv0), 96'(1));
    check("single_timeout", 96'(timeout_o), 96'(0));

    // Status never ready: POLL_LIMIT reads, a reset write, sticky timeout, no result pulse.
    exp_cfg(3'b010, 24'h000001, 32'h40, 32'h7F);
    for (int k = 0; k < PL; k++) exp_r(32'd2, 32'h0);
    exp_w(32'd7, 32'd1);
    rv0 = rv_count;
    start_job(3'b010, 24'h000001, 32'h40, 32'h7F);
    send_sample(6'd5, 6'd10, 1'b1, 0);
    wait_idle("timeout");
    compare_log("timeout");
    check("timeout_flag", 96'(timeout_o), 96'(1));
    check("timeout_no_pulse", 96'(rv_count - rv0), 96'(0));
    check("timeout_result_held", 96'(result_o), 96'(9));

    // Back-pressure on every request; the new start must clear the sticky timeout.
    ready_delay = 5;
    exp_cfg(3'b101, 24'h8A1234, 32'h100, 32'h1FF);
    exp_sample(6'd33, 6'd63, 0);
    exp_done(5'd5, 0);
    rv0 = rv_count;
    start_job(3'b101, 24'h8A1234, 32'h100, 32'h1FF);
    check("start_clears_timeout", 96'(timeout_o), 96'(0));
    send_sample(6'd33, 6'd63, 1'b1, 0);
    wait_idle("bp");
    compare_log("bp");
    check("bp_result", 96'(result_o), 96'(5));
    check("bp_pulse", 96'(rv_count - rv0), 96'(1));

    // Three samples with gaps, matches on the last allowed poll, and a start while busy.
    ready_delay = 0;
    exp_cfg(3'b000, 24'hFFFFFF, 32'hFFFFFFFF, 32'h12345678);
    exp_sample(6'd1, 6'd2, PL - 1);
    exp_sample(6'd63, 6'd0, 0);
    exp_sample(6'd0, 6'd63, 0);
    exp_done(5'd17, PL - 1);
    rv0 = rv_count;
    start_job(3'b000, 24'hFFFFFF, 32'hFFFFFFFF, 32'h12345678);
    send_sample(6'd1, 6'd2, 1'b0, 2);
    start_i = 1'b1; cfg_binding_i = 3'b111;
    @(negedge clk);
    start_i = 1'b0;
    send_sample(6'd63, 6'd0, 1'b0, 2);
    send_sample(6'd0, 6'd63, 1'b1, 2);
    wait_idle("multi");
    compare_log("multi");
    check("multi_result", 96'(result_o), 96'(17));
    check("multi_pulse", 96'(rv_count - rv0), 96'(1));

    // Reset while a POLL_OUT read is pending, then a clean job.
    ready_delay = 5;
    rd_q.push_back(32'h2);
    start_job(3'b001, 24'h000ABC, 32'h10, 32'h20);
    send_sample(6'd7, 6'd7, 1'b1, 0);
    for (int c = 0; c < 500; c++) begin
      if (log_q.size() >= 10) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("pre_reset_pending", 96'({csr_req_valid_o, csr_wr_en_o, csr_addr_o}), 96'({2'b10, 32'd2}));
    rst_ni = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    exp_q.delete(); log_q.delete(); rd_q.delete();
    ready_delay = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    exp_cfg(3'b110, 24'h00FF00, 32'h200, 32'h2FF);
    exp_sample(6'd12, 6'd40, 0);
    exp_done(5'd31, 0);
    rv0 = rv_count;
    start_job(3'b110, 24'h00FF00, 32'h200, 32'h2FF);
    send_sample(6'd12, 6'd40, 1'b1, 0);
    wait_idle("post_reset");
    compare_log("post_reset");
    check("post_reset_result", 96'(result_o), 96'(31));
    check("post_reset_pulse", 96'(rv_count - rv0), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hdc_csr_sequencer.md
HDC_CSR_SEQUENCER -- requirements
Module: hdc_csr_sequencer

Interface
REQ-001 Parameters SHALL be:
- CSR_WIDTH, 32, CSR data width
- CSR_ADDR_WIDTH, 32, CSR address width
- POLL_LIMIT, 1024, maximum status polls per wait before timeout
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk_i, in, 1, single clock
- rst_ni, in, 1, asynchronous active-low reset
- start_i, in, 1, begin job when IDLE; ignored otherwise
- cfg_binding_i, in, 3, CSR_P_BINDING payload
- cfg_bundling_i, in, 24, CSR_P_BUNDLING payload
- cfg_am_base_i, in, CSR_WIDTH, CSR_AM_BASE payload
- cfg_am_max_i, in, CSR_WIDTH, CSR_AM_MAX payload
- smp_valid_i, in, 1, sample valid
- smp_ready_o, out, 1, sample accepted
- smp_value_i, in, 6, sample value
- smp_shift_i, in, 6, shift amount
- smp_last_i, in, 1, final sample of job
- csr_addr_o, out, CSR_ADDR_WIDTH, CSR address
- csr_wr_data_o, out, CSR_WIDTH, write data
- csr_wr_en_o, out, 1, write (1) or read (0)
- csr_req_valid_o, out, 1, request valid
- csr_req_ready_i, in, 1, request accepted
- csr_rd_data_i, in, CSR_WIDTH, read data
- csr_rsp_valid_i, in, 1, read data valid
- busy_o, out, 1, job in progress
- result_valid_o, out, 1, one-cycle result strobe
- result_o, out, 5, class output
- timeout_o, out, 1, sticky; set on poll timeout, cleared on next start

Function
REQ-003 The block SHALL use a CSR transfer that completes in the cycle where csr_req_valid_o && csr_req_ready_i; a read SHALL capture csr_rd_data_i in that cycle only if csr_rsp_valid_i=1, otherwise the read SHALL be reissued.
REQ-004 csr_req_valid_o SHALL stay high, with addr, data and wr_en stable, until the transfer completes.
REQ-005 States SHALL be IDLE, W_RST, W_BIND, W_BUND, W_BASE, W_MAX, W_START, GET_SMP, POLL_RDY, W_IN, W_CLR, W_DONE, POLL_OUT, FINISH, ERR.
REQ-006 IDLE SHALL go to W_RST on start_i, latching all cfg_* inputs and clearing timeout_o.
REQ-007 The configuration chain SHALL issue these writes, each advancing on completion:
- W_RST: addr 7, data 1
- W_BIND: addr 3, {29'b0, binding}
- W_BUND: addr 4, {8'b0, bundling}
- W_BASE: addr 5, am_base
- W_MAX: addr 6, am_max
- W_START: addr 0, data 1, then go to GET_SMP
REQ-008 GET_SMP SHALL assert smp_ready_o, latch value, shift and last on handshake, and go to POLL_RDY; smp_ready_o SHALL be 0 in every other state.
REQ-009 POLL_RDY SHALL read addr 2 and go to W_IN when the captured bit1 is 1; otherwise it SHALL re-read.
REQ-010 W_IN SHALL write addr 1 with data {18'b0, 1'b0, shift[5:0], value[5:0], 1'b1}, then go to W_CLR.
REQ-011 W_CLR SHALL write addr 1 with bit0 cleared and the remaining fields unchanged, then go to GET_SMP, or to W_DONE if last=1.
REQ-012 W_DONE SHALL write addr 1 with data 1<<13, then go to POLL_OUT.
REQ-013 POLL_OUT SHALL read addr 2 and, when bit2 is 1, latch bits[7:3] into result_o and go to FINISH; otherwise it SHALL re-read.
REQ-014 FINISH SHALL pulse result_valid_o for one cycle and go to IDLE.
REQ-015 A poll counter SHALL reset on entry to POLL_RDY or POLL_OUT and increment on each completed read without a match.
REQ-016 When the poll count reaches POLL_LIMIT without a match, the block SHALL go to ERR and set timeout_o; it SHALL NOT issue a pulse on result_valid_o.
REQ-017 ERR SHALL issue a write of addr 7, data 1, then go to IDLE.
REQ-018 busy_o SHALL be 1 in every state except IDLE.
REQ-019 result_o SHALL hold its value until the next FINISH.
REQ-020 start_i while busy SHALL be ignored.
REQ-021 A match on the final allowed poll SHALL take priority over timeout.

Reset
REQ-022 On rst_ni=0, asynchronously: state IDLE; all outputs 0; latched cfg, sample and counter registers 0.
REQ-023 Reset during a pending CSR request SHALL drop csr_req_valid_o immediately; no partial transfer state SHALL remain after release.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Config: start with binding=3'b101, bundling=24'h8A1234, base=0x100, max=0x1FF, ready always 1 -> writes seen in order 7/1, 3/0x5, 4/0x8A1234, 5/0x100, 6/0x1FF, 0/1.
- Single sample: value=6'd21, shift=6'd3, last=1; status reads 0x2, then 0x2, then 0x2|(5'd9<<3)|0x4 -> writes to addr 1 of 0x1AB, 0x1AA, 0x2000; result_o=9 with one-cycle result_valid_o.
- Back-pressure: csr_req_ready_i low for 5 cycles on every request -> addr and data stable throughout, same transfer order as Config.
- Timeout: POLL_LIMIT=4 and status always 0 in POLL_RDY -> exactly 4 reads, then write 7/1, timeout_o=1, no result_valid_o; the next start clears timeout_o.
- Multi-sample: 3 samples with smp_valid_i gaps of 2 cycles -> 3 W_IN/W_CLR pairs, then one W_DONE.
- Reset mid-job: rst_ni low during POLL_OUT -> all outputs 0, busy_o=0, and a new job runs normally from W_RST.
